// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: EXE->WB handshake, load-response wait FSM, load data alignment and a stalled-load watchdog.
// Define MS_LD_EXT_EN to enable byte/halfword extraction; otherwise every load returns the full word.
module mem_stage_ctrl #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        es2ms_valid,
   input  logic [38:0] es_rf_zip,
   input  logic [31:0] es_pc,
   input  logic [2:0]  es_ld_op,
   output logic        ms_allowin,
   input  logic [31:0] data_sram_rdata,
   input  logic        data_sram_data_ok,
   input  logic        ws_allowin,
   output logic        ms2ws_valid,
   output logic [69:0] ms2ws_bus,
   output logic [37:0] ms_rf_zip,
   output logic        ms_timeout
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_WAIT = 2'b01;
   localparam logic [1:0] ST_HOLD = 2'b10;

   localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 32'd1);

   logic        ms_valid_q;
   logic [1:0]  state_q,   state_d;
   logic [38:0] zip_q;
   logic [31:0] pc_q;
   logic [31:0] rbuf_q;
   logic [7:0]  wcnt_q,    wcnt_d;
   logic        timeout_q, timeout_d;

   logic        res_from_mem_s;
   logic        dok_hit_s;
   logic        ready_go_s;
   logic        allowin_s;
   logic        accept_s;
   logic [31:0] rdata_s;
   logic [31:0] ld_data_s;
   logic [31:0] wdata_s;

`ifdef MS_LD_EXT_EN
   logic [2:0]  ld_op_q;

   function automatic logic [31:0] ld_extend(input logic [2:0]  op,
                                             input logic [1:0]  addr,
                                             input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{addr, 3'b000} +: 8];
      h = addr[1] ? word[31:16] : word[15:0];
      case (op)
         3'b001:  return {{24{b[7]}}, b};
         3'b010:  return {{16{h[15]}}, h};
         3'b011:  return {24'h000000, b};
         3'b100:  return {16'h0000, h};
         default: return word;
      endcase
   endfunction
`else
   logic unused_ld_op_s;
   assign unused_ld_op_s = ^es_ld_op;
`endif

   assign res_from_mem_s = zip_q[38];
   // data_ok only counts while a load is actually waiting for it
   assign dok_hit_s      = (state_q == ST_WAIT) & data_sram_data_ok;
   assign ready_go_s     = ~res_from_mem_s | dok_hit_s | (state_q == ST_HOLD);
   assign allowin_s      = ~ms_valid_q | (ready_go_s & ws_allowin);
   assign accept_s       = es2ms_valid & allowin_s;
   assign rdata_s        = dok_hit_s ? data_sram_rdata : rbuf_q;

`ifdef MS_LD_EXT_EN
   assign ld_data_s = ld_extend(ld_op_q, zip_q[1:0], rdata_s);
`else
   assign ld_data_s = rdata_s;
`endif

   assign wdata_s = res_from_mem_s ? ld_data_s : zip_q[31:0];

   // Next FSM state: a departing or empty slot takes whatever arrives, a stalled load moves to HOLD on data_ok
   always_comb begin
      state_d = state_q;
      if (allowin_s) begin
         if (es2ms_valid) begin
            state_d = es_rf_zip[38] ? ST_WAIT : ST_HOLD;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (dok_hit_s) begin
         state_d = ST_HOLD;
      end else begin
         state_d = state_q;
      end
   end

   // Watchdog: count cycles spent waiting, latch the flag once the limit is reached
   always_comb begin
      wcnt_d    = 8'd0;
      timeout_d = timeout_q;
      if ((state_q == ST_WAIT) && !dok_hit_s) begin
         wcnt_d = (wcnt_q == 8'hFF) ? wcnt_q : (wcnt_q + 8'd1);
      end else begin
         wcnt_d = 8'd0;
      end
      if ((state_q == ST_WAIT) && (wcnt_q >= WAIT_LAST)) begin
         timeout_d = 1'b1;
      end else begin
         timeout_d = timeout_q;
      end
   end

   // Stage state, payload latch and read-data buffer
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid_q <= 1'b0;
         state_q    <= ST_IDLE;
         zip_q      <= 39'd0;
         pc_q       <= 32'd0;
         rbuf_q     <= 32'd0;
         wcnt_q     <= 8'd0;
         timeout_q  <= 1'b0;
`ifdef MS_LD_EXT_EN
         ld_op_q    <= 3'd0;
`endif
      end else begin
         if (allowin_s) begin
            ms_valid_q <= es2ms_valid;
         end
         if (accept_s) begin
            zip_q   <= es_rf_zip;
            pc_q    <= es_pc;
`ifdef MS_LD_EXT_EN
            ld_op_q <= es_ld_op;
`endif
         end
         if (dok_hit_s) begin
            rbuf_q <= data_sram_rdata;
         end
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign ms_allowin  = allowin_s;
   assign ms2ws_valid = ms_valid_q & ready_go_s;
   assign ms2ws_bus   = {zip_q[37], zip_q[36:32], wdata_s, pc_q};
   assign ms_rf_zip   = {zip_q[37] & ms_valid_q, zip_q[36:32], wdata_s};
   assign ms_timeout  = timeout_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed cases plus random traffic against a transaction-level model.
module tb_mem_stage_ctrl;

   localparam int WMAX = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        es2ms_valid;
   logic [38:0] es_rf_zip;
   logic [31:0] es_pc;
   logic [2:0]  es_ld_op;
   logic        ms_allowin;
   logic [31:0] data_sram_rdata;
   logic        data_sram_data_ok;
   logic        ws_allowin;
   logic        ms2ws_valid;
   logic [69:0] ms2ws_bus;
   logic [37:0] ms_rf_zip;
   logic        ms_timeout;

   always #5 clk = ~clk;

   mem_stage_ctrl #(.WAIT_MAX(WMAX)) dut (
      .clk(clk), .resetn(resetn), .es2ms_valid(es2ms_valid), .es_rf_zip(es_rf_zip),
      .es_pc(es_pc), .es_ld_op(es_ld_op), .ms_allowin(ms_allowin),
      .data_sram_rdata(data_sram_rdata), .data_sram_data_ok(data_sram_data_ok),
      .ws_allowin(ws_allowin), .ms2ws_valid(ms2ws_valid), .ms2ws_bus(ms2ws_bus),
      .ms_rf_zip(ms_rf_zip), .ms_timeout(ms_timeout)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [69:0] exp_q[$];
   bit          res = 1'b0, r_load = 1'b0, r_got = 1'b0, exp_to = 1'b0;
   bit          m_ready = 1'b0, m_allow = 1'b1, mon_en = 1'b0;
   int          wait_cnt = 0;
   logic [31:0] r_plan = 32'd0;

`ifdef MS_LD_EXT_EN
   function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                            input logic [31:0] w);
      logic [31:0] b;
      logic [31:0] h;
      b = w >> (8 * addr[1:0]);
      h = w >> (16 * addr[1]);
      case (op)
         3'd1:    return {{24{b[7]}}, b[7:0]};
         3'd2:    return {{16{h[15]}}, h[15:0]};
         3'd3:    return b & 32'h0000_00FF;
         3'd4:    return h & 32'h0000_FFFF;
         default: return w;
      endcase
   endfunction
`endif

   task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // One cycle of stimulus; the model advances on the clock edge
   task automatic step(input bit ev, input logic [38:0] zip, input logic [31:0] pc,
                       input logic [2:0] op, input bit ws, input bit dok, input logic [31:0] plan);
      bit          hit;
      logic [31:0] wd;
      hit               = res && r_load && !r_got && dok;
      es2ms_valid       = ev;
      es_rf_zip         = zip;
      es_pc             = pc;
      es_ld_op          = op;
      ws_allowin        = ws;
      data_sram_data_ok = dok;
      data_sram_rdata   = hit ? r_plan : $urandom;
      m_ready           = res && (!r_load || r_got || hit);
      m_allow           = !res || (m_ready && ws);
      @(posedge clk);
      if (res && r_load && !r_got) begin
         wait_cnt++;
         if (wait_cnt >= WMAX) exp_to = 1'b1;
      end
      if (hit) r_got = 1'b1;
      if (m_allow) begin
         res = ev;
         if (ev) begin
            r_load   = zip[38];
            r_got    = 1'b0;
            wait_cnt = 0;
            r_plan   = plan;
`ifdef MS_LD_EXT_EN
            wd = zip[38] ? ref_load(op, zip[31:0], plan) : zip[31:0];
`else
            wd = zip[38] ? plan : zip[31:0];
`endif
            exp_q.push_back({zip[37], zip[36:32], wd, pc});
         end
      end
      #1;
   endtask

   // Monitor: compare handshake, watchdog and the presented payload against the scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         chk("ms2ws_valid", 70'(ms2ws_valid), 70'(m_ready));
         chk("ms_allowin", 70'(ms_allowin), 70'(m_allow));
         chk("ms_timeout", 70'(ms_timeout), 70'(exp_to));
         if (!res) chk("rf_zip_we_idle", 70'(ms_rf_zip[37]), 70'd0);
         if (m_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL scoreboard_empty: got output %h, expected none", ms2ws_bus);
            end else begin
               chk("ms2ws_bus", ms2ws_bus, exp_q[0]);
               chk("ms_rf_zip", 70'(ms_rf_zip), 70'(exp_q[0][69:32]));
               if (ws_allowin) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"},   70'(ms2ws_valid), 70'd0);
      chk({tag, "_allowin"}, 70'(ms_allowin),  70'd1);
      chk({tag, "_bus"},     ms2ws_bus,        70'd0);
      chk({tag, "_rf_zip"},  70'(ms_rf_zip),   70'd0);
      chk({tag, "_timeout"}, 70'(ms_timeout),  70'd0);
   endtask

   initial begin
      resetn = 1'b0; es2ms_valid = 1'b0; es_rf_zip = 39'd0; es_pc = 32'd0; es_ld_op = 3'd0;
      ws_allowin = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
      #12;
      chk_reset_outputs("reset");
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1; mon_en = 1'b1;

      // Non-load passes through in one cycle
      step(1, {1'b0, 1'b1, 5'd3, 32'h0000_1234}, 32'h1c00_0000, 3'd0, 1, 0, 32'd0);
      step(0, 39'd0, 32'd0, 3'd0, 1, 0, 32'd0);
      // Word load, data_ok on the third cycle of residence
      step(1, {1'b1, 1'b1, 5'd7, 32'h0000_0100}, 32'h1c00_0004, 3'd0, 1, 0, 32'hDEAD_BEEF);
      step(0, 39'd0, 32'd0, 3'd0, 1, 0, 32'd0);
      step(0, 39'd0, 32'd0, 3'd0, 1, 0, 32'd0);
      step(0, 39'd0, 32'd0, 3'd0, 1, 1, 32'd0);
      // data_ok while WB stalls; a stray data_ok in HOLD must be ignored
      step(1, {1'b1, 1'b1, 5'd8, 32'h0000_0200}, 32'h1c00_0008, 3'd0, 1, 0, 32'hDEAD_BEEF);
      step(0, 39'd0, 32'd0, 3'd0, 0, 1, 32'd0);
      step(0, 39'd0, 32'd0, 3'd0, 0, 0, 32'd0);
      step(0, 39'd0, 32'd0, 3'd0, 0, 1, 32'd0);
      step(0, 39'd0, 32'd0, 3'd0, 0, 0, 32'd0);
      step(0, 39'd0, 32'd0, 3'd0, 0, 0, 32'd0);
      step(0, 39'd0, 32'd0, 3'd0, 1, 0, 32'd0);
      // Sub-word loads at byte offset 2, back to back with immediate data
      step(1, {1'b1, 1'b1, 5'd1, 32'h0000_1002}, 32'h1c00_0010, 3'd1, 1, 0, 32'h80F1_7F01);
      step(1, {1'b1, 1'b1, 5'd2, 32'h0000_1002}, 32'h1c00_0014, 3'd3, 1, 1, 32'h80F1_7F01);
      step(1, {1'b1, 1'b1, 5'd4, 32'h0000_1002}, 32'h1c00_0018, 3'd2, 1, 1, 32'h80F1_7F01);
      step(0, 39'd0, 32'd0, 3'd0, 1, 1, 32'd0);
      // Watchdog: six cycles without data, flag must remain afterwards
      step(1, {1'b1, 1'b0, 5'd5, 32'h0000_0300}, 32'h1c00_0020, 3'd0, 1, 0, 32'h1357_9BDF);
      repeat (6) step(0, 39'd0, 32'd0, 3'd0, 1, 0, 32'd0);
      step(0, 39'd0, 32'd0, 3'd0, 1, 1, 32'd0);
      step(0, 39'd0, 32'd0, 3'd0, 1, 0, 32'd0);
      chk("timeout_sticky", 70'(ms_timeout), 70'd1);
      // Reset in the middle of a load; a late data_ok must not revive it
      step(1, {1'b1, 1'b1, 5'd9, 32'h0000_0040}, 32'h1c00_0030, 3'd0, 1, 0, 32'hCAFE_F00D);
      step(0, 39'd0, 32'd0, 3'd0, 1, 0, 32'd0);
      mon_en = 1'b0;
      resetn = 1'b0;
      #2;
      chk_reset_outputs("midload_reset");
      res = 1'b0; r_got = 1'b0; exp_to = 1'b0; wait_cnt = 0; exp_q.delete();
      es2ms_valid = 1'b0; data_sram_data_ok = 1'b0;
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1; mon_en = 1'b1;
      step(0, 39'd0, 32'd0, 3'd0, 1, 1, 32'd0);
      chk("post_reset_bus", ms2ws_bus, 70'd0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom % 4) != 0, {1'($urandom % 2), 38'({$urandom, $urandom})}, $urandom,
              3'($urandom % 8), ($urandom % 4) != 0, ($urandom % 3) == 0, $urandom);
      end
      repeat (12) step(0, 39'd0, 32'd0, 3'd0, 1, 1, 32'd0);
      chk("scoreboard_drain", 70'(exp_q.size()), 70'd0);

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
